i2c_master_gen: RTL and testbench

Parametrised I2C master for multi-byte register traffic. Supports write and read transfers of 0..MAX_LEN bytes to a 7-bit slave address with a programmable SCL rate. Samples the real slave ACK and flags NACK. Byte-level streaming handshakes on both write and read paths. Sits between local control FSMs and external I2C slaves on an open-drain SDA line.

---
 rtl/i2c_master_gen.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_i2c_master_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_gen.sv
// I2C master for multi-byte register reads and writes. The clock divider produces quarter-bit ticks.
// Every bus change happens on a tick. SDA is only ever pulled low or released.
module i2c_master_gen #(
  parameter int CLK_DIV = 250,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             scl,
  inout  wire              sda,
  output logic             busy,
  output logic             done,
  output logic             nack
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WR_BYTE  = 4'd4;
  localparam logic [3:0] S_WR_ACK   = 4'd5;
  localparam logic [3:0] S_RD_BYTE  = 4'd6;
  localparam logic [3:0] S_RD_ACK   = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             rw_q, rw_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             tx_ready_q, tx_ready_d;
  logic             wait_q, wait_d;
  logic             ack_q, ack_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tick;
  logic             sda_in;

  assign tick   = busy_q && (cnt_q == CNT_MAX);
  assign sda_in = sda;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rem_d      = rem_q;
    rw_d       = rw_q;
    scl_d      = scl_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    nack_d     = nack_q;
    tx_ready_d = tx_ready_q;
    wait_d     = wait_q;
    ack_d      = ack_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The cycle carrying the done pulse never accepts a new request.
        if (start && !done_q) begin
          state_d  = S_START;
          phase_d  = 2'd0;
          busy_d   = 1'b1;
          nack_d   = 1'b0;
          shift_d  = {addr, rw};
          rw_d     = rw;
          rem_d    = (len > LEN_MAX) ? LEN_MAX : len;
          scl_d    = 1'b1;
          sda_oe_d = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          if (phase_q == 2'd0) begin
            sda_oe_d = 1'b1;
            phase_d  = 2'd1;
          end else begin
            scl_d    = 1'b0;
            sda_oe_d = ~shift_q[7];
            state_d  = S_ADDR;
            phase_d  = 2'd0;
            bit_d    = 3'd7;
          end
        end
      end

      S_STOP: begin
        if (phase_q == 2'd3) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          phase_d = 2'd0;
        end else if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1) scl_d = 1'b1;
          if (phase_q == 2'd2) sda_oe_d = 1'b0;
        end
      end

      default: begin
        if (state_q == S_WR_BYTE && wait_q) begin
          // While waiting for a write byte, SCL stays low, which stretches the clock.
          if (tx_valid && tx_ready_q) begin
            shift_d    = tx_data;
            tx_ready_d = 1'b0;
          end else if (tick && !tx_ready_q) begin
            wait_d   = 1'b0;
            sda_oe_d = ~shift_q[7];
            phase_d  = 2'd0;
            bit_d    = 3'd7;
          end
        end else if (tick) begin
          case (phase_q)
            2'd0: phase_d = 2'd1;
            2'd1: begin
              scl_d   = 1'b1;
              phase_d = 2'd2;
            end
            2'd2: begin
              phase_d = 2'd3;
              ack_d   = sda_in;
              if (state_q == S_RD_BYTE) begin
                shift_d = {shift_q[6:0], sda_in};
                if (bit_q == 3'd0) begin
                  rx_data_d  = {shift_q[6:0], sda_in};
                  rx_valid_d = 1'b1;
                end
              end
            end
            default: begin
              phase_d = 2'd0;
              scl_d   = 1'b0;
              case (state_q)
                S_ADDR, S_WR_BYTE: begin
                  if (bit_q != 3'd0) begin
                    bit_d    = bit_q - 3'd1;
                    shift_d  = {shift_q[6:0], 1'b0};
                    sda_oe_d = ~shift_q[6];
                  end else begin
                    state_d  = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                    sda_oe_d = 1'b0;
                  end
                end
                S_RD_BYTE: begin
                  if (bit_q != 3'd0) begin
                    bit_d = bit_q - 3'd1;
                  end else begin
                    state_d  = S_RD_ACK;
                    sda_oe_d = (rem_q > LEN_ONE);
                  end
                end
                S_ADDR_ACK: begin
                  if (ack_q || rem_q == '0) begin
                    nack_d   = nack_q | ack_q;
                    state_d  = S_STOP;
                    sda_oe_d = 1'b1;
                  end else if (rw_q) begin
                    state_d  = S_RD_BYTE;
                    bit_d    = 3'd7;
                    sda_oe_d = 1'b0;
                  end else begin
                    state_d    = S_WR_BYTE;
                    wait_d     = 1'b1;
                    tx_ready_d = 1'b1;
                    sda_oe_d   = 1'b0;
                  end
                end
                S_WR_ACK: begin
                  if (ack_q) begin
                    nack_d   = 1'b1;
                    state_d  = S_STOP;
                    sda_oe_d = 1'b1;
                  end else begin
                    rem_d = (rem_q != '0) ? rem_q - LEN_ONE : rem_q;
                    if (rem_q <= LEN_ONE) begin
                      state_d  = S_STOP;
                      sda_oe_d = 1'b1;
                    end else begin
                      state_d    = S_WR_BYTE;
                      wait_d     = 1'b1;
                      tx_ready_d = 1'b1;
                      sda_oe_d   = 1'b0;
                    end
                  end
                end
                default: begin
                  rem_d = (rem_q != '0) ? rem_q - LEN_ONE : rem_q;
                  if (rem_q <= LEN_ONE) begin
                    state_d  = S_STOP;
                    sda_oe_d = 1'b1;
                  end else begin
                    state_d  = S_RD_BYTE;
                    bit_d    = 3'd7;
                    sda_oe_d = 1'b0;
                  end
                end
              endcase
            end
          endcase
        end
      end
    endcase

    cnt_d = (busy_q && busy_d) ? (tick ? '0 : cnt_q + 1'b1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      rem_q      <= '0;
      rw_q       <= 1'b0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      wait_q     <= 1'b0;
      ack_q      <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      rw_q       <= rw_d;
      scl_q      <= scl_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      tx_ready_q <= tx_ready_d;
      wait_q     <= wait_d;
      ack_q      <= ack_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign scl      = scl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign nack     = nack_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_i2c_master_gen.sv
// Directed bench for i2c_master_gen. An I2C slave model decodes the bus and acks or serves reads.
// A byte feeder models the write-data producer.
module tb_i2c_master_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [4:0] len;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       scl;
  logic       busy;
  logic       done;
  logic       nack;
  wire        sda_w;
  logic       slv_low;

  assign sda_w = slv_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_master_gen #(.CLK_DIV(4), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .scl(scl), .sda(sda_w),
    .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors of DUT outputs
  int cyc = 0;
  int done_cnt = 0, ready_cyc = 0, stretch_err = 0, hs_cnt = 0;
  logic [7:0] rx_got[$];
  always @(posedge clk) begin
    cyc++;
    if (rst_n && tx_valid && tx_ready) hs_cnt++;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (rx_valid) rx_got.push_back(rx_data);
      if (tx_ready) begin
        ready_cyc++;
        if (scl) stretch_err++;
      end
    end
  end

  // Write-byte producer: waits `stall` cycles after tx_ready rises before offering the next byte.
  logic [7:0] tx_stream[$];
  int tx_ptr = 0, stall = 0, wcnt = 0;
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        tx_valid = 1'b0;
        tx_ptr++;
      end else if (rst_n && tx_ready && tx_ptr < tx_stream.size()) begin
        if (wcnt >= stall) begin
          tx_data  = tx_stream[tx_ptr];
          tx_valid = 1'b1;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // I2C slave model and bus decoder
  logic ack_en = 1'b1;
  logic [7:0] rd_stream[$];
  logic [7:0] bus_bytes[$];
  logic       bus_acks[$];
  int   rd_ptr = 0, start_cnt = 0, stop_cnt = 0, rise_t0 = 0, rise_t1 = 0;
  int   s_cnt = 0;
  bit   s_addr = 0, s_rd = 0, s_mack = 0;
  logic [7:0] s_sh = 8'h00, s_byte = 8'h00;
  logic p_scl = 1'b1, p_sda = 1'b1, sda_now;
  initial begin
    slv_low = 1'b0;
    forever begin
      @(negedge clk);
      sda_now = (sda_w === 1'b0) ? 1'b0 : 1'b1;
      if (!rst_n) begin
        slv_low = 1'b0; s_cnt = 0; s_addr = 0; s_rd = 0;
      end else if (p_scl && scl && p_sda && !sda_now) begin
        start_cnt++; s_cnt = 0; s_addr = 1; s_rd = 0; slv_low = 1'b0;
      end else if (p_scl && scl && !p_sda && sda_now) begin
        stop_cnt++; slv_low = 1'b0;
      end else if (!p_scl && scl) begin
        if (s_addr && s_cnt == 0) rise_t0 = cyc;
        if (s_addr && s_cnt == 1) rise_t1 = cyc;
        if (s_cnt < 8) s_sh = {s_sh[6:0], sda_now};
        else begin
          s_mack = sda_now;
          bus_acks.push_back(sda_now);
        end
        s_cnt++;
      end else if (p_scl && !scl) begin
        if (s_cnt == 8) begin
          bus_bytes.push_back(s_sh);
          if (s_addr) s_rd = s_sh[0];
          slv_low = (s_addr || !s_rd) ? ack_en : 1'b0;
        end else if (s_cnt == 9) begin
          s_cnt   = 0;
          slv_low = 1'b0;
          if (s_rd && (s_addr ? ack_en : !s_mack)) begin
            s_byte  = (rd_ptr < rd_stream.size()) ? rd_stream[rd_ptr] : 8'hFF;
            rd_ptr++;
            slv_low = !s_byte[7];
          end
          s_addr = 0;
        end else if (s_cnt >= 1 && s_cnt <= 7 && s_rd && !s_addr) begin
          slv_low = !s_byte[7 - s_cnt];
        end
      end
      p_scl = scl;
      p_sda = sda_now;
    end
  end

  // Per-transfer baselines so checks look only at the traffic of the transfer under test.
  int b_bytes, b_acks, b_rx, b_done, b_stop, b_start, b_hs, b_rdy, b_str;
  logic busy_at_start, nack_at_start;

  task automatic snap();
    b_bytes = bus_bytes.size(); b_acks = bus_acks.size(); b_rx = rx_got.size();
    b_done = done_cnt; b_stop = stop_cnt; b_start = start_cnt;
    b_hs = hs_cnt; b_rdy = ready_cyc; b_str = stretch_err;
  endtask

  task automatic kick(input logic [6:0] a, input logic r, input logic [4:0] l);
    @(negedge clk);
    addr = a; rw = r; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_at_start = busy;
    nack_at_start = nack;
  endtask

  task automatic run_xfer(input string tag, input logic [6:0] a, input logic r, input logic [4:0] l);
    int n;
    snap();
    kick(a, r, l);
    n = 0;
    while (done_cnt == b_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_timeout"}, (done_cnt == b_done) ? 1 : 0, 0);
    repeat (20) @(negedge clk);
    $display("xfer %s addr=0x%02h rw=%0d len=%0d bus_bytes=%0d done=%0d nack=%0d cycles=%0d",
             tag, a, r, l, bus_bytes.size() - b_bytes, done_cnt - b_done, nack, n);
  endtask

  task automatic chk_byte(input string tag, input int k, input logic [7:0] exp);
    check($sformatf("%s_byte%0d", tag, k),
          (b_bytes + k < bus_bytes.size()) ? 32'(bus_bytes[b_bytes + k]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic chk_ack(input string tag, input int k, input logic exp);
    check($sformatf("%s_ack%0d", tag, k),
          (b_acks + k < bus_acks.size()) ? 32'(bus_acks[b_acks + k]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic chk_rx(input string tag, input int k, input logic [7:0] exp);
    check($sformatf("%s_rx%0d", tag, k),
          (b_rx + k < rx_got.size()) ? 32'(rx_got[b_rx + k]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; addr = 7'h00; rw = 1'b0; len = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_w, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two-byte write, all bytes acked
    tx_stream.push_back(8'h12);
    tx_stream.push_back(8'h34);
    run_xfer("wr2", 7'h50, 1'b0, 5'd2);
    check("wr2_nbytes", bus_bytes.size() - b_bytes, 3);
    chk_byte("wr2", 0, 8'hA0);
    chk_byte("wr2", 1, 8'h12);
    chk_byte("wr2", 2, 8'h34);
    for (int k = 0; k < 3; k++) chk_ack("wr2", k, 1'b0);
    check("wr2_starts", start_cnt - b_start, 1);
    check("wr2_stops", stop_cnt - b_stop, 1);
    check("wr2_scl_period", rise_t1 - rise_t0, 16);
    check("wr2_handshakes", hs_cnt - b_hs, 2);
    check("wr2_done_cnt", done_cnt - b_done, 1);
    check("wr2_nack", nack, 0);
    check("wr2_busy_at_start", busy_at_start, 1);
    check("wr2_busy_end", busy, 0);

    // Address NACK
    ack_en = 1'b0;
    run_xfer("nak", 7'h51, 1'b0, 5'd1);
    ack_en = 1'b1;
    check("nak_nbytes", bus_bytes.size() - b_bytes, 1);
    chk_byte("nak", 0, 8'hA2);
    chk_ack("nak", 0, 1'b1);
    check("nak_nack", nack, 1);
    check("nak_stops", stop_cnt - b_stop, 1);
    check("nak_done_cnt", done_cnt - b_done, 1);
    check("nak_tx_ready_cycles", ready_cyc - b_rdy, 0);

    // Address-only probe; its start also clears the sticky nack
    run_xfer("probe", 7'h3C, 1'b0, 5'd0);
    check("probe_nack_cleared", nack_at_start, 0);
    check("probe_nbytes", bus_bytes.size() - b_bytes, 1);
    chk_byte("probe", 0, 8'h78);
    chk_ack("probe", 0, 1'b0);
    check("probe_stops", stop_cnt - b_stop, 1);
    check("probe_done_cnt", done_cnt - b_done, 1);
    check("probe_nack", nack, 0);
    check("probe_tx_ready_cycles", ready_cyc - b_rdy, 0);

    // Three-byte read
    rd_stream.push_back(8'hDE);
    rd_stream.push_back(8'hAD);
    rd_stream.push_back(8'hBE);
    run_xfer("rd3", 7'h68, 1'b1, 5'd3);
    check("rd3_nbytes", bus_bytes.size() - b_bytes, 4);
    chk_byte("rd3", 0, 8'hD1);
    chk_byte("rd3", 1, 8'hDE);
    chk_byte("rd3", 2, 8'hAD);
    chk_byte("rd3", 3, 8'hBE);
    chk_ack("rd3", 0, 1'b0);
    chk_ack("rd3", 1, 1'b0);
    chk_ack("rd3", 2, 1'b0);
    chk_ack("rd3", 3, 1'b1);
    check("rd3_rx_count", rx_got.size() - b_rx, 3);
    chk_rx("rd3", 0, 8'hDE);
    chk_rx("rd3", 1, 8'hAD);
    chk_rx("rd3", 2, 8'hBE);
    check("rd3_stops", stop_cnt - b_stop, 1);
    check("rd3_done_cnt", done_cnt - b_done, 1);
    check("rd3_nack", nack, 0);

    // Clock stretch: write byte withheld for 100 cycles after tx_ready rises
    stall = 100;
    tx_stream.push_back(8'h5A);
    run_xfer("stretch", 7'h50, 1'b0, 5'd1);
    stall = 0;
    check("stretch_ready_cycles", ready_cyc - b_rdy, 101);
    check("stretch_scl_high_while_waiting", stretch_err - b_str, 0);
    check("stretch_nbytes", bus_bytes.size() - b_bytes, 2);
    chk_byte("stretch", 1, 8'h5A);
    chk_ack("stretch", 1, 1'b0);
    check("stretch_handshakes", hs_cnt - b_hs, 1);
    check("stretch_done_cnt", done_cnt - b_done, 1);

    // Reset asserted during the third data bit of a write
    tx_stream.push_back(8'h12);
    tx_stream.push_back(8'h34);
    snap();
    kick(7'h50, 1'b0, 5'd2);
    n = 0;
    while (!(hs_cnt > b_hs && !s_addr && s_cnt == 2 && !scl) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("mrst_reach_bit3", (n < 5000) ? 1 : 0, 1);
    check("mrst_scl_low_before", scl, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_scl", scl, 1);
    check("mrst_sda", sda_w, 1);
    check("mrst_busy", busy, 0);
    check("mrst_tx_ready", tx_ready, 0);
    repeat (3) @(negedge clk);
    check("mrst_no_stop", stop_cnt - b_stop, 0);
    check("mrst_no_done", done_cnt - b_done, 0);
    $display("xfer reset_mid_write addr=0x50 rw=0 len=2 reset_after_cycles=%0d", n);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_xfer("after_rst", 7'h3C, 1'b0, 5'd0);
    check("after_rst_nbytes", bus_bytes.size() - b_bytes, 1);
    chk_byte("after_rst", 0, 8'h78);
    chk_ack("after_rst", 0, 1'b0);
    check("after_rst_done_cnt", done_cnt - b_done, 1);
    check("after_rst_nack", nack, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
